// File: rtl/mult_arb_pkg.sv
// Shared types and the round-robin pick function for mult_arbiter.
// Build macro: MULT_ARB_PIPE_EN adds the CALC2 state (extra product register stage).
package mult_arb_pkg;

`ifdef MULT_ARB_PIPE_EN
    typedef enum logic [1:0] {IDLE, CALC, RESP, CALC2} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
`endif

    // Upper bound on requesters that rr_pick can scan.
    localparam int MAX_REQ = 64;
    localparam int IDX_W   = 6;

    // First set bit of valid[0 +: n], starting at ptr and wrapping.
    // Returns the found flag; idx is valid only when found.
    function automatic logic rr_pick(
        input  logic [MAX_REQ-1:0] valid,
        input  int unsigned        ptr,
        input  int unsigned        n,
        output int unsigned        idx
    );
        logic        found;
        int unsigned cand;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            cand = ptr + k;
            if (cand >= n) cand = cand - n;
            if (k < n && !found && valid[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/mult_arbiter_multiplier.sv
// Combinational unsigned SIZE x SIZE multiplier shared by the arbiter.
module multiplier #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0]   i_a,
    input  logic [SIZE-1:0]   i_b,
    output logic [2*SIZE-1:0] o_prod
);

    assign o_prod = (2*SIZE)'(i_a) * (2*SIZE)'(i_b);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier among N_REQ valid/ready requesters.
// Build macro: MULT_ARB_PIPE_EN inserts a CALC2 stage after the multiplier.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*SIZE-1:0] req_a,
    input  logic [N_REQ*SIZE-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [2*SIZE-1:0]     rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy
);

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_gnt_id;
    logic [ID_W-1:0]     r_rsp_id;
    logic [SIZE-1:0]     r_op_a;
    logic [SIZE-1:0]     r_op_b;
    logic [2*SIZE-1:0]   r_rsp_data;
    logic                r_rsp_valid;
    logic                r_busy;
`ifdef MULT_ARB_PIPE_EN
    logic [2*SIZE-1:0]   r_prod_q;
`endif

    logic                w_found;
    logic [ID_W-1:0]     w_gnt;
    logic [N_REQ-1:0]    w_req_ready;
    logic                w_accept;
    logic [SIZE-1:0]     w_sel_a;
    logic [SIZE-1:0]     w_sel_b;
    logic [2*SIZE-1:0]   w_prod;
    logic [ID_W-1:0]     w_ptr_next;

    always_comb begin : arb_pick
        int unsigned v_idx;
        v_idx   = 0;
        w_found = rr_pick(MAX_REQ'(req_valid), 32'(r_rr_ptr), N_REQ, v_idx);
        w_gnt   = ID_W'(v_idx);
    end

    // Gating with rst_n keeps req_ready low while reset is held.
    always_comb begin
        w_req_ready = '0;
        if (rst_n && r_state == IDLE && w_found)
            w_req_ready[w_gnt] = 1'b1;
    end

    assign w_accept   = |w_req_ready;
    assign w_sel_a    = req_a[w_gnt*SIZE +: SIZE];
    assign w_sel_b    = req_b[w_gnt*SIZE +: SIZE];
    assign w_ptr_next = (r_gnt_id == ID_W'(N_REQ-1)) ? '0 : r_gnt_id + 1'b1;

    multiplier #(.SIZE(SIZE)) u_mult (
        .i_a    (r_op_a),
        .i_b    (r_op_b),
        .o_prod (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_gnt_id    <= '0;
            r_rsp_id    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MULT_ARB_PIPE_EN
            r_prod_q    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_gnt_id <= w_gnt;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
`ifdef MULT_ARB_PIPE_EN
                    r_prod_q    <= w_prod;
                    r_state     <= CALC2;
`else
                    r_rsp_data  <= w_prod;
                    r_rsp_id    <= r_gnt_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
`endif
                end
`ifdef MULT_ARB_PIPE_EN
                CALC2: begin
                    r_rsp_data  <= r_prod_q;
                    r_rsp_id    <= r_gnt_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
`endif
                RESP: begin
                    // Pointer advances only when the response retires.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rr_ptr    <= w_ptr_next;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_busy;

endmodule
